// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to enable the MADD/MADDU multiply-accumulate ops (op 6/7).
module mdu_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;
    localparam logic [2:0] OpMadd  = 3'd6;
    localparam logic [2:0] OpMaddu = 3'd7;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic [WIDTH-1:0]  pend_hi_q, pend_lo_q;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, mag_b_safe, src_b_safe;
    logic [WIDTH-1:0]   q_m, r_m, q_s, r_s, q_u, r_u;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               is_long;
    logic [CntW-1:0]    lat;

    // Operand arithmetic; results are latched into pend_* on the accept edge.
    always_comb begin
        prod_s = {{WIDTH{srcA[WIDTH-1]}}, srcA} * {{WIDTH{srcB[WIDTH-1]}}, srcB};
        prod_u = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};

        a_neg      = srcA[WIDTH-1];
        b_neg      = srcB[WIDTH-1];
        mag_a      = a_neg ? -srcA : srcA;
        mag_b      = b_neg ? -srcB : srcB;
        mag_b_safe = (mag_b == '0) ? WIDTH'(1) : mag_b;
        src_b_safe = (srcB == '0) ? WIDTH'(1) : srcB;

        // Magnitude divide then fix signs; most-negative / -1 falls out as lo=srcA, hi=0.
        q_m = mag_a / mag_b_safe;
        r_m = mag_a % mag_b_safe;
        q_s = (a_neg ^ b_neg) ? -q_m : q_m;
        r_s = a_neg ? -r_m : r_m;
        q_u = srcA / src_b_safe;
        r_u = srcA % src_b_safe;

        res_hi  = '0;
        res_lo  = '0;
        is_long = 1'b0;
        lat     = CntW'(MULT_LAT);
        unique case (op)
            OpMult: begin
                {res_hi, res_lo} = prod_s;
                is_long          = 1'b1;
            end
            OpMultu: begin
                {res_hi, res_lo} = prod_u;
                is_long          = 1'b1;
            end
            OpDiv: begin
                is_long = 1'b1;
                lat     = CntW'(DIV_LAT);
                if (srcB == '0) begin
                    res_lo = '1;
                    res_hi = srcA;
                end else begin
                    res_lo = q_s;
                    res_hi = r_s;
                end
            end
            OpDivu: begin
                is_long = 1'b1;
                lat     = CntW'(DIV_LAT);
                if (srcB == '0) begin
                    res_lo = '1;
                    res_hi = srcA;
                end else begin
                    res_lo = q_u;
                    res_hi = r_u;
                end
            end
`ifdef MDU_MADD_EN
            OpMadd: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
                is_long          = 1'b1;
            end
            OpMaddu: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
                is_long          = 1'b1;
            end
`else
            OpMadd, OpMaddu: begin
                is_long = 1'b0;
            end
`endif
            default: begin
                is_long = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_long) begin
                            pend_hi_q <= res_hi;
                            pend_lo_q <= res_lo;
                            cnt_q     <= lat;
                            busy_q    <= 1'b1;
                            state_q   <= StRun;
                        end else if (op == OpMthi) begin
                            hi_q <= srcA;
                        end else if (op == OpMtlo) begin
                            lo_q <= srcA;
                        end
                    end
                end
                StRun: begin
                    // start is ignored here: no queueing while a long op is in flight.
                    if (cnt_q == CntW'(1)) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latencies, MULT/DIV corner results, MT ops, reset abort.
module tb_mdu_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vecs = 0;
    int errs = 0;

    mdu_unit #(
        .WIDTH    (32),
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Caller sits at a negedge; issues op, counts busy cycles (bounded), checks HI/LO held mid-run.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
        logic [31:0] hi0, lo0;
        int n;
        hi0   = hi;
        lo0   = lo;
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " hi held"}, hi, hi0);
        chk({tag, " lo held"}, lo, lo0);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1;
        op    = o;
        srcA  = a;
        @(negedge clk);
        start = 1'b0;
        chk("mt busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        srcA    = '0;
        srcB    = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);

        // Back-to-back ops: each run_op starts on the first busy==0 cycle.
        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5);
        chk("mult hi", hi, 32'hFFFF_FFFF);
        chk("mult lo", lo, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5);
        chk("multu hi", hi, 32'h0000_0001);
        chk("multu lo", lo, 32'hFFFF_FFFE);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10);
        chk("div lo", lo, 32'hFFFF_FFFD);
        chk("div hi", hi, 32'hFFFF_FFFF);
        run_op("divu", 3'd3, 32'h0000_0007, 32'h0000_0002, 10);
        chk("divu lo", lo, 32'h0000_0003);
        chk("divu hi", hi, 32'h0000_0001);
        run_op("div0", 3'd2, 32'h0000_0005, 32'h0000_0000, 10);
        chk("div0 lo", lo, 32'hFFFF_FFFF);
        chk("div0 hi", hi, 32'h0000_0005);
        run_op("divu0", 3'd3, 32'h8000_0009, 32'h0000_0000, 10);
        chk("divu0 lo", lo, 32'hFFFF_FFFF);
        chk("divu0 hi", hi, 32'h8000_0009);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        chk("divovf lo", lo, 32'h8000_0000);
        chk("divovf hi", hi, 32'h0000_0000);
        run_op("div+-", 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 10);
        chk("div+- lo", lo, 32'hFFFF_FFFD);
        chk("div+- hi", hi, 32'h0000_0001);

        // MTHI while busy is ignored; srcA change mid-run must not alter the product.
        start = 1'b1;
        op    = 3'd0;
        srcA  = 32'd3;
        srcB  = 32'd4;
        @(negedge clk);
        chk("mult2 busy", {31'd0, busy}, 32'd1);
        op    = 3'd4;
        srcA  = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            if (busy === 1'b1) @(negedge clk);
        end
        chk("mult2 idle", {31'd0, busy}, 32'd0);
        chk("mthi-ignored hi", hi, 32'h0000_0000);
        chk("mult2 lo", lo, 32'h0000_000C);
        mt(3'd5, 32'h0000_ABCD);
        chk("mtlo lo", lo, 32'h0000_ABCD);
        chk("mtlo hi", hi, 32'h0000_0000);
        mt(3'd4, 32'h0000_5678);
        chk("mthi hi", hi, 32'h0000_5678);

`ifdef MDU_MADD_EN
        mt(3'd4, 32'h0000_0000);
        mt(3'd5, 32'hFFFF_FFFF);
        run_op("maddu", 3'd7, 32'd1, 32'd1, 5);
        chk("maddu hi", hi, 32'h0000_0001);
        chk("maddu lo", lo, 32'h0000_0000);
        run_op("madd", 3'd6, 32'hFFFF_FFFF, 32'd1, 5);
        chk("madd hi", hi, 32'h0000_0000);
        chk("madd lo", lo, 32'hFFFF_FFFF);
`else
        mt(3'd4, 32'h0000_0000);
        mt(3'd5, 32'hFFFF_FFFF);
        start = 1'b1;
        op    = 3'd7;
        srcA  = 32'd1;
        srcB  = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("maddu-off busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("maddu-off hi", hi, 32'h0000_0000);
        chk("maddu-off lo", lo, 32'hFFFF_FFFF);
`endif

        // Reset mid-DIV aborts: no later commit.
        start = 1'b1;
        op    = 3'd3;
        srcA  = 32'd100;
        srcB  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort hi", hi, 32'h0);
        chk("abort lo", lo, 32'h0);
        repeat (15) @(negedge clk);
        chk("no-commit busy", {31'd0, busy}, 32'd0);
        chk("no-commit hi", hi, 32'h0);
        chk("no-commit lo", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
